// File: rtl/code_converter.sv
// code_converter: registered 4-bit code translator between BCD, Excess-3,
// binary and Gray codes. Input word {A,B,C,D}, result word {a,b,c,d}.
// Optional macro CODE_CONVERTER_ERR_EN adds a registered invalid-code flag (err).
module code_converter (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d
`ifdef CODE_CONVERTER_ERR_EN
    ,
    output logic       err
`endif
);

    localparam int unsigned W = 4;

    localparam logic [1:0] MODE_BCD_XS3  = 2'b00;
    localparam logic [1:0] MODE_XS3_BCD  = 2'b01;
    localparam logic [1:0] MODE_BIN_GRAY = 2'b10;
    localparam logic [1:0] MODE_GRAY_BIN = 2'b11;

    localparam logic [W-1:0] XS3_BIAS = W'(3);
    localparam logic [W-1:0] BCD_MAX  = W'(9);
    localparam logic [W-1:0] XS3_MIN  = W'(3);
    localparam logic [W-1:0] XS3_MAX  = W'(12);

    logic [W-1:0] x_c;
    logic [W-1:0] conv_c;
    logic         inv_c;
    logic [W-1:0] y_d;
    logic [W-1:0] y_q;

    // Combinational conversion of the sampled nibble; invalid codes force zero.
    always_comb begin
        x_c    = {A, B, C, D};
        conv_c = '0;
        inv_c  = 1'b0;
        case (mode)
            MODE_BCD_XS3: begin
                conv_c = x_c + XS3_BIAS;
                inv_c  = (x_c > BCD_MAX);
            end
            MODE_XS3_BCD: begin
                conv_c = x_c - XS3_BIAS;
                inv_c  = (x_c < XS3_MIN) || (x_c > XS3_MAX);
            end
            MODE_BIN_GRAY: begin
                conv_c = x_c ^ (x_c >> 1);
            end
            MODE_GRAY_BIN: begin
                conv_c[3] = x_c[3];
                conv_c[2] = conv_c[3] ^ x_c[2];
                conv_c[1] = conv_c[2] ^ x_c[1];
                conv_c[0] = conv_c[1] ^ x_c[0];
            end
            default: begin
                conv_c = '0;
            end
        endcase
        y_d = inv_c ? '0 : conv_c;
    end

    // Output register; holds while en is low, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
        end else if (en) begin
            y_q <= y_d;
        end
    end

    assign a = y_q[3];
    assign b = y_q[2];
    assign c = y_q[1];
    assign d = y_q[0];

`ifdef CODE_CONVERTER_ERR_EN
    logic err_d;
    logic err_q;

    assign err_d = inv_c;

    // Invalid-code flag registered alongside the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (en) begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_code_converter.sv
// Self-checking bench for code_converter with a behavioural reference model.
module tb_code_converter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] x;
    wire  [3:0] y_obs;
`ifdef CODE_CONVERTER_ERR_EN
    wire        err_obs;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    code_converter dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .A    (x[3]),
        .B    (x[2]),
        .C    (x[1]),
        .D    (x[0]),
        .a    (y_obs[3]),
        .b    (y_obs[2]),
        .c    (y_obs[1]),
        .d    (y_obs[0])
`ifdef CODE_CONVERTER_ERR_EN
        ,
        .err  (err_obs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: conversion computed from the code definitions.
    function automatic logic [3:0] model_y(input logic [1:0] m, input logic [3:0] v);
        int iv;
        int r;
        iv = int'(v);
        r  = 0;
        case (m)
            2'b00: r = (iv <= 9) ? iv + 3 : 0;
            2'b01: r = (iv >= 3 && iv <= 12) ? iv - 3 : 0;
            2'b10: r = iv ^ (iv / 2);
            default: begin
                // binary is the prefix XOR of all right shifts of the Gray word
                r = iv;
                for (int s = 1; s < 4; s++) r = r ^ (iv >> s);
            end
        endcase
        return 4'(r);
    endfunction

    function automatic logic model_err(input logic [1:0] m, input logic [3:0] v);
        int iv;
        iv = int'(v);
        if (m == 2'b00) return iv > 9;
        if (m == 2'b01) return (iv < 3) || (iv > 12);
        return 1'b0;
    endfunction

    // Drive one sample at the falling edge and wait just past the next rising edge.
    task automatic apply(input logic [1:0] m, input logic [3:0] v, input logic e);
        @(negedge clk);
        mode = m;
        x    = v;
        en   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        en   = 1'b1;
        mode = 2'b10;
        x    = 4'b1111;
        #1;
        total_cnt++;
        if (y_obs !== 4'b0000) $display("FAIL reset_async y=%b exp=0000", y_obs);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (y_obs !== 4'b0000) $display("FAIL reset_hold cyc%0d y=%b exp=0000", i, y_obs);
            else pass_cnt++;
`ifdef CODE_CONVERTER_ERR_EN
            total_cnt++;
            if (err_obs !== 1'b0) $display("FAIL reset_err cyc%0d err=%b exp=0", i, err_obs);
            else pass_cnt++;
`endif
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (y_obs !== 4'b1000) $display("FAIL reset_first_sample y=%b exp=1000", y_obs);
        else pass_cnt++;
    endtask

    task automatic test_bcd_xs3();
        for (int i = 0; i < 16; i++) begin
            apply(2'b00, 4'(i), 1'b1);
            total_cnt++;
            if (y_obs !== ((i <= 9) ? 4'(i + 3) : 4'b0000))
                $display("FAIL bcd_xs3 x=%0d y=%b exp=%b", i, y_obs, (i <= 9) ? 4'(i + 3) : 4'b0000);
            else pass_cnt++;
`ifdef CODE_CONVERTER_ERR_EN
            total_cnt++;
            if (err_obs !== (i > 9)) $display("FAIL bcd_xs3_err x=%0d err=%b exp=%b", i, err_obs, i > 9);
            else pass_cnt++;
`endif
        end
    endtask

    task automatic test_xs3_bcd();
        logic [3:0] xs [3] = '{4'b1000, 4'b0011, 4'b1101};
        logic [3:0] ye [3] = '{4'b0101, 4'b0000, 4'b0000};
        logic       ee [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            apply(2'b01, xs[i], 1'b1);
            total_cnt++;
            if (y_obs !== ye[i]) $display("FAIL xs3_bcd x=%b y=%b exp=%b", xs[i], y_obs, ye[i]);
            else pass_cnt++;
`ifdef CODE_CONVERTER_ERR_EN
            total_cnt++;
            if (err_obs !== ee[i]) $display("FAIL xs3_bcd_err x=%b err=%b exp=%b", xs[i], err_obs, ee[i]);
            else pass_cnt++;
`else
            if (ee[i] === 1'bx) $display("unexpected table entry");
`endif
        end
    endtask

    task automatic test_gray();
        logic [3:0] g;
        apply(2'b10, 4'b1011, 1'b1);
        total_cnt++;
        if (y_obs !== 4'b1110) $display("FAIL bin_gray x=1011 y=%b exp=1110", y_obs);
        else pass_cnt++;
        apply(2'b11, 4'b1110, 1'b1);
        total_cnt++;
        if (y_obs !== 4'b1011) $display("FAIL gray_bin x=1110 y=%b exp=1011", y_obs);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            apply(2'b10, 4'(i), 1'b1);
            g = y_obs;
            apply(2'b11, g, 1'b1);
            total_cnt++;
            if (y_obs !== 4'(i)) $display("FAIL gray_round_trip x=%0d gray=%b back=%b", i, g, y_obs);
            else pass_cnt++;
        end
    endtask

    task automatic test_enable_hold();
        apply(2'b00, 4'b0101, 1'b1);
        total_cnt++;
        if (y_obs !== 4'b1000) $display("FAIL hold_load y=%b exp=1000", y_obs);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            apply(2'b00, 4'b0001, 1'b0);
            total_cnt++;
            if (y_obs !== 4'b1000) $display("FAIL hold_cyc%0d y=%b exp=1000", i, y_obs);
            else pass_cnt++;
        end
        apply(2'b00, 4'b0001, 1'b1);
        total_cnt++;
        if (y_obs !== 4'b0100) $display("FAIL hold_reenable y=%b exp=0100", y_obs);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) apply(2'b10, (i % 2 == 0) ? 4'b0110 : 4'b1001, 1'b1);
        total_cnt++;
        if (y_obs !== 4'b1101) $display("FAIL async_pre y=%b exp=1101", y_obs);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (y_obs !== 4'b0000) $display("FAIL async_mid y=%b exp=0000", y_obs);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] exp_y;
        logic       exp_e;
        logic [1:0] m;
        logic [3:0] v;
        logic       e;
        exp_y = y_obs;
`ifdef CODE_CONVERTER_ERR_EN
        exp_e = err_obs;
`else
        exp_e = 1'b0;
`endif
        for (int i = 0; i < 200; i++) begin
            m = 2'($urandom_range(0, 3));
            v = 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 3) != 0);
            apply(m, v, e);
            if (e) begin
                exp_y = model_y(m, v);
                exp_e = model_err(m, v);
            end
            total_cnt++;
            if (y_obs !== exp_y) $display("FAIL random%0d m=%b x=%b en=%b y=%b exp=%b", i, m, v, e, y_obs, exp_y);
            else pass_cnt++;
`ifdef CODE_CONVERTER_ERR_EN
            total_cnt++;
            if (err_obs !== exp_e) $display("FAIL random_err%0d m=%b x=%b err=%b exp=%b", i, m, v, err_obs, exp_e);
            else pass_cnt++;
`endif
        end
        if (exp_e === 1'bx) $display("unexpected model state");
    endtask

    initial begin
        test_reset();
        test_bcd_xs3();
        test_xs3_bcd();
        test_gray();
        test_enable_hold();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
